// File: rtl/bitrev_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-reversal frame sequencer.
package bitrev_ctrl_pkg;

  typedef enum logic [3:0] {
    StCoreRst,
    StLoad,
    StWr,
    StWrGap,
    StStart,
    StWaitDone,
    StRd,
    StRdGap,
    StRdCap,
    StOut,
    StErr
  } state_e;

  localparam int unsigned FRAME_CNT_W = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitrev_frame_ctrl.sv
// Frame sequencer for the bit-reversal core: loads N_WORDS, starts the core,
// waits for done with a timeout, streams the results out, then resets the core.
module bitrev_frame_ctrl
  import bitrev_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned N_WORDS        = 4,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic [DATA_W-1:0]      s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [DATA_W-1:0]      m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DATA_W-1:0]      core_din_o,
  output logic                   core_write_o,
  output logic                   core_start_o,
  output logic                   core_read_o,
  output logic                   core_rst_o,
  input  logic [DATA_W-1:0]      core_dout_i,
  input  logic                   core_done_i,
  input  logic                   clr_err_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int unsigned IdxW    = cnt_w(N_WORDS);
  localparam int unsigned RstCntW = cnt_w(RST_CYCLES);
  localparam int unsigned ToCntW  = cnt_w(TIMEOUT_CYCLES);

  localparam logic [IdxW-1:0]    IdxLast = IdxW'(N_WORDS - 1);
  localparam logic [RstCntW-1:0] RstLast = RstCntW'(RST_CYCLES - 1);
  localparam logic [ToCntW-1:0]  ToLast  = ToCntW'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [RstCntW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [ToCntW-1:0]      to_cnt_q, to_cnt_d, to_cnt_inc;
  logic [DATA_W-1:0]      din_q, din_d;
  logic [DATA_W-1:0]      m_data_q, m_data_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   m_valid_q, m_valid_d;
  logic                   write_q, write_d;
  logic                   start_q, start_d;
  logic                   read_q, read_d;
  logic                   core_rst_q, core_rst_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  assign to_cnt_inc = to_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    din_d       = din_q;
    m_data_d    = m_data_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StCoreRst: begin
        if (rst_cnt_q == RstLast) begin
          rst_cnt_d = '0;
          idx_d     = '0;
          state_d   = StLoad;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StLoad: begin
        if (s_valid_i) begin
          din_d   = s_data_i;
          state_d = StWr;
        end
      end
      StWr: state_d = StWrGap;
      StWrGap: begin
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StStart;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StLoad;
        end
      end
      StStart: begin
        to_cnt_d = '0;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        if (core_done_i) begin
          state_d = StRd;
        end else begin
          to_cnt_d = to_cnt_inc;
          if (to_cnt_inc == ToLast) state_d = StErr;
        end
      end
      StRd:    state_d = StRdCap;
      StRdCap: begin
        m_data_d = core_dout_i;
        state_d  = StOut;
      end
      StOut: begin
        if (m_ready_i) begin
          if (idx_q == IdxLast) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            idx_d       = '0;
            rst_cnt_d   = '0;
            state_d     = StCoreRst;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRdGap;
          end
        end
      end
      StRdGap: state_d = StRd;
      StErr: begin
        if (clr_err_i) begin
          idx_d     = '0;
          rst_cnt_d = '0;
          state_d   = StCoreRst;
        end
      end
      default: state_d = StCoreRst;
    endcase

    // Outputs are registered from the next state so they line up with the state itself.
    write_d    = (state_d == StWr);
    start_d    = (state_d == StStart);
    read_d     = (state_d == StRd);
    m_valid_d  = (state_d == StOut);
    err_d      = (state_d == StErr);
    core_rst_d = (state_d == StCoreRst) || (state_d == StErr);
    busy_d     = !((state_d == StLoad) && (idx_d == '0));
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StCoreRst;
      idx_q       <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      din_q       <= '0;
      m_data_q    <= '0;
      frame_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      write_q     <= 1'b0;
      start_q     <= 1'b0;
      read_q      <= 1'b0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      din_q       <= din_d;
      m_data_q    <= m_data_d;
      frame_cnt_q <= frame_cnt_d;
      m_valid_q   <= m_valid_d;
      write_q     <= write_d;
      start_q     <= start_d;
      read_q      <= read_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign s_ready_o    = (state_q == StLoad);
  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign core_din_o   = din_q;
  assign core_write_o = write_q;
  assign core_start_o = start_q;
  assign core_read_o  = read_q;
  assign core_rst_o   = core_rst_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_bitrev_frame_ctrl.sv
// Directed bench for bitrev_frame_ctrl with a behavioural bit-reversal core model.
module tb_bitrev_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] core_din_o;
  logic        core_write_o, core_start_o, core_read_o, core_rst_o;
  logic [31:0] core_dout = '0;
  logic        core_done = 1'b0;
  logic        clr_err_i = 1'b0;
  logic        busy_o, err_o;
  logic [15:0] frame_cnt_o;

  int n_checks = 0;
  int n_fail = 0;

  bitrev_frame_ctrl #(
    .DATA_W(32), .N_WORDS(4), .RST_CYCLES(4), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst_ni(rst_ni),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .core_din_o(core_din_o), .core_write_o(core_write_o), .core_start_o(core_start_o),
    .core_read_o(core_read_o), .core_rst_o(core_rst_o), .core_dout_i(core_dout),
    .core_done_i(core_done), .clr_err_i(clr_err_i),
    .busy_o(busy_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  // Core model: stores writes, raises done 10 cycles after start, returns reversed words.
  logic [31:0] core_mem [4];
  int          wr_ptr = 0, rd_ptr = 0, done_cnt = 0;
  logic        done_en = 1'b1;

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (core_rst_o) begin
      wr_ptr    <= 0;
      rd_ptr    <= 0;
      done_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      if (core_write_o) begin
        core_mem[wr_ptr % 4] <= core_din_o;
        wr_ptr <= wr_ptr + 1;
      end
      if (core_start_o && done_en) done_cnt <= 10;
      else if (done_cnt > 1) done_cnt <= done_cnt - 1;
      else if (done_cnt == 1) begin
        done_cnt  <= 0;
        core_done <= 1'b1;
      end
      if (core_read_o) begin
        core_dout <= bitrev(core_mem[rd_ptr % 4]);
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Pulse monitor; cyc of a pulse equals the cyc seen at the negedge inside that pulse.
  int cyc = 0, wr_tot = 0, st_tot = 0, rd_tot = 0, last_rd_cyc = 0, last_st_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_write_o) wr_tot <= wr_tot + 1;
    if (core_start_o) begin
      st_tot      <= st_tot + 1;
      last_st_cyc <= cyc;
    end
    if (core_read_o) begin
      rd_tot      <= rd_tot + 1;
      last_rd_cyc <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic count_core_rst(output int n);
    n = 0;
    while (core_rst_o === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] data, input int gap, output int acc_cyc,
                           output bit ok);
    int n = 0;
    repeat (gap) @(negedge clk);
    s_data_i  = data;
    s_valid_i = 1'b1;
    while (s_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok      = (s_ready_o === 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic recv_word(input int stall, output logic [31:0] data, output int vcyc,
                           output bit ok, output int unstable);
    int n = 0;
    int r0;
    while (m_valid_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok       = (m_valid_o === 1'b1);
    vcyc     = cyc;
    data     = m_data_o;
    unstable = 0;
    r0       = rd_tot;
    m_ready_i = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      if (m_valid_o !== 1'b1 || m_data_o !== data || rd_tot != r0) unstable++;
    end
    m_ready_i = 1'b1;
    @(negedge clk);
    m_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge clk);
    n_checks++;
    if (core_rst_o !== 1'b1 || s_ready_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rst=%b rdy=%b busy=%b err=%b, required 1 0 0 0",
               core_rst_o, s_ready_o, busy_o, err_o);
    end
    n_checks++;
    if ({core_write_o, core_start_o, core_read_o, m_valid_o} !== 4'b0 || frame_cnt_o !== 16'd0)
    begin
      n_fail++;
      $display("FAIL reset_out: wr/st/rd/mv=%b frame_cnt=%0d, required 0000 and 0",
               {core_write_o, core_start_o, core_read_o, m_valid_o}, frame_cnt_o);
    end
    rst_ni = 1'b1;
    count_core_rst(n);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL reset_hold: core_rst_o high %0d cycles, required 4", n);
    end
    n_checks++;
    if (s_ready_o !== 1'b1 || busy_o !== 1'b0 || frame_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_load: rdy=%b busy=%b frame_cnt=%0d, required 1 0 0",
               s_ready_o, busy_o, frame_cnt_o);
    end
  endtask

  task automatic test_nominal();
    logic [31:0] words [4];
    logic [31:0] exp [4];
    logic [31:0] got;
    int acc [4];
    int w0, s0, r0, vc, unst, n;
    bit ok;
    words = '{32'h0000_0001, 32'h8000_0000, 32'hF0F0_F0F0, 32'h1234_5678};
    exp   = '{32'h8000_0000, 32'h0000_0001, 32'h0F0F_0F0F, 32'h1E6A_2C48};
    w0 = wr_tot; s0 = st_tot; r0 = rd_tot;
    done_en   = 1'b1;
    m_ready_i = 1'b1;  // ready with nothing valid must not do anything
    for (int i = 0; i < 4; i++) begin
      send_word(words[i], 0, acc[i], ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL nom_accept%0d: s_ready_o never high, required accept", i);
      end
      if (i == 0) begin
        n_checks++;
        if (core_write_o !== 1'b1 || core_din_o !== words[0] || s_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL nom_wr_latency: write=%b din=%h rdy=%b, required 1 %h 0",
                   core_write_o, core_din_o, s_ready_o, words[0]);
        end
      end
    end
    n_checks++;
    if (acc[3] - acc[0] !== 9) begin
      n_fail++;
      $display("FAIL nom_b2b_rate: 4 accepts span %0d cycles, required 9", acc[3] - acc[0]);
    end
    n_checks++;
    if (m_valid_o !== 1'b0 || rd_tot != r0) begin
      n_fail++;
      $display("FAIL nom_early_out: m_valid=%b reads=%0d, required 0 0", m_valid_o, rd_tot - r0);
    end
    for (int i = 0; i < 4; i++) begin
      recv_word(0, got, vc, ok, unst);
      n_checks++;
      if (!ok || got !== exp[i]) begin
        n_fail++;
        $display("FAIL nom_data%0d: got %h valid=%b, required %h", i, got, ok, exp[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (vc - last_rd_cyc !== 2) begin
          n_fail++;
          $display("FAIL nom_rd_latency: read->valid %0d cycles, required 2", vc - last_rd_cyc);
        end
      end
    end
    n_checks++;
    if (frame_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL nom_frame_cnt: got %0d, required 1", frame_cnt_o);
    end
    count_core_rst(n);
    n_checks++;
    if (n !== 4 || s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_post_rst: core_rst %0d cycles rdy=%b, required 4 and 1", n, s_ready_o);
    end
    n_checks++;
    if (wr_tot - w0 !== 4 || st_tot - s0 !== 1 || rd_tot - r0 !== 4) begin
      n_fail++;
      $display("FAIL nom_pulses: wr=%0d st=%0d rd=%0d, required 4 1 4",
               wr_tot - w0, st_tot - s0, rd_tot - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [4];
    logic [31:0] exp [4];
    logic [31:0] got;
    int acc, r0, vc, unst, n;
    bit ok;
    words = '{32'h0000_0003, 32'h0000_FFFF, 32'h00F0_000F, 32'h7654_3210};
    exp   = '{32'hC000_0000, 32'hFFFF_0000, 32'hF000_0F00, 32'h084C_2A6E};
    r0 = rd_tot;
    for (int i = 0; i < 4; i++) send_word(words[i], 0, acc, ok);
    for (int i = 0; i < 4; i++) begin
      recv_word((i == 2) ? 7 : 0, got, vc, ok, unst);
      n_checks++;
      if (!ok || got !== exp[i]) begin
        n_fail++;
        $display("FAIL bp_data%0d: got %h valid=%b, required %h", i, got, ok, exp[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (unst !== 0) begin
          n_fail++;
          $display("FAIL bp_stall_stable: %0d unstable stall cycles, required 0", unst);
        end
      end
    end
    n_checks++;
    if (rd_tot - r0 !== 4 || frame_cnt_o !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_reads: reads=%0d frame_cnt=%0d, required 4 and 2",
               rd_tot - r0, frame_cnt_o);
    end
    count_core_rst(n);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL bp_post_rst: core_rst %0d cycles, required 4", n);
    end
  endtask

  task automatic test_timeout();
    int acc, n, w0;
    bit ok;
    done_en = 1'b0;
    w0 = wr_tot;
    for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + i, 0, acc, ok);
    n = 0;
    while (err_o !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (err_o !== 1'b1 || cyc - last_st_cyc !== 1024) begin
      n_fail++;
      $display("FAIL to_latency: err=%b after %0d cycles from start, required 1 after 1024",
               err_o, cyc - last_st_cyc);
    end
    s_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (core_rst_o !== 1'b1 || s_ready_o !== 1'b0 || m_valid_o !== 1'b0 || err_o !== 1'b1 ||
        wr_tot - w0 !== 4) begin
      n_fail++;
      $display("FAIL to_err_state: rst=%b rdy=%b mv=%b err=%b wr=%0d, required 1 0 0 1 4",
               core_rst_o, s_ready_o, m_valid_o, err_o, wr_tot - w0);
    end
    s_valid_i = 1'b0;
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b0 || core_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_clear: err=%b rst=%b, required 0 1", err_o, core_rst_o);
    end
    count_core_rst(n);
    n_checks++;
    if (n !== 4 || s_ready_o !== 1'b1 || frame_cnt_o !== 16'd2) begin
      n_fail++;
      $display("FAIL to_recover: rst %0d cycles rdy=%b frame_cnt=%0d, required 4 1 2",
               n, s_ready_o, frame_cnt_o);
    end
  endtask

  task automatic test_gaps_and_reset();
    int acc, n, w0;
    bit ok;
    done_en = 1'b0;
    w0 = wr_tot;
    for (int i = 0; i < 4; i++) send_word(32'h5500_0000 + i, (i == 0) ? 0 : 5, acc, ok);
    repeat (5) @(negedge clk);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_tot - w0 !== 4 || err_o !== 1'b0 || core_rst_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_writes: wr=%0d err=%b rst=%b busy=%b, required 4 0 0 1",
               wr_tot - w0, err_o, core_rst_o, busy_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (core_rst_o !== 1'b1 || frame_cnt_o !== 16'd0 || s_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: rst=%b frame_cnt=%0d rdy=%b, required 1 0 0",
               core_rst_o, frame_cnt_o, s_ready_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    count_core_rst(n);
    n_checks++;
    if (n !== 4 || s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_recover: rst %0d cycles rdy=%b, required 4 and 1", n, s_ready_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got;
    int acc, vc, unst;
    bit ok;
    done_en = 1'b1;
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    n_checks++;
    if (frame_cnt_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: frame_cnt=%h, required ffff", frame_cnt_o);
    end
    for (int i = 0; i < 4; i++) send_word(32'h0000_0010 << i, 0, acc, ok);
    for (int i = 0; i < 4; i++) recv_word(0, got, vc, ok, unst);
    n_checks++;
    if (got !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL wrap_data: last word %h, required 01000000", got);
    end
    n_checks++;
    if (frame_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_cnt: frame_cnt=%0d, required 0", frame_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_gaps_and_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
